// File: rtl/snake_cell_painter_if.sv
// Cell-map write port: the painter presents address/code, the map RAM accepts with ready.
interface snake_cell_painter_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [13:0] wr_addr;
    logic [1:0]  wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/snake_cell_painter.sv
// Snapshots the snake position list, erases the previously painted cells, paints the new
// ones into the cell map and flags head-on-body self-collision.
module snake_cell_painter #(
    parameter int LEN      = 31,
    parameter int W        = 16,
    parameter int CELLS    = 9600,
    parameter int SNAKE_ID = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [LEN-1:0][W-1:0]     pos_num_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      self_hit_o,
    snake_cell_painter_if.master      wr
);

    localparam logic [W-1:0] UNUSED     = {W{1'b1}};
    localparam logic [W-1:0] CELLS_W    = W'(CELLS);
    localparam logic [1:0]   PAINT_CODE = 2'(SNAKE_ID + 1);
    localparam logic [4:0]   LAST_IDX   = 5'(LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_e;

    state_e                  state_q;
    logic [4:0]              idx_q;
    logic [LEN-1:0][W-1:0]   new_q;
    logic [LEN-1:0][W-1:0]   old_q;
    logic                    self_hit_q;

    logic [W-1:0]            cur_s;
    logic                    cur_valid_s;
    logic                    advance_s;
    logic                    hit_s;

    // Decode the entry under idx and the write it presents; invalid entries skip without a write.
    always_comb begin
        cur_s       = (state_q == S_DRAW) ? new_q[idx_q] : old_q[idx_q];
        cur_valid_s = ((state_q == S_ERASE) || (state_q == S_DRAW)) &&
                      (cur_s != UNUSED) && (cur_s < CELLS_W);
        advance_s   = cur_valid_s ? wr.wr_ready : 1'b1;
        hit_s       = (state_q == S_DRAW) && (idx_q != 5'd0) && cur_valid_s &&
                      (cur_s == new_q[0]);
    end

    assign wr.wr_valid = cur_valid_s;
    assign wr.wr_addr  = cur_valid_s ? cur_s[13:0] : 14'd0;
    assign wr.wr_data  = (cur_valid_s && (state_q == S_DRAW)) ? PAINT_CODE : 2'b00;

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign self_hit_o = self_hit_q;

    // Repaint sequencer: snapshot, erase old cells, draw new cells, commit the snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 5'd0;
            new_q      <= {(LEN*W){1'b1}};
            old_q      <= {(LEN*W){1'b1}};
            self_hit_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        new_q      <= pos_num_i;
                        self_hit_q <= 1'b0;
                        idx_q      <= 5'd0;
                        state_q    <= S_ERASE;
                    end
                end
                S_ERASE: begin
                    if (advance_s) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= 5'd0;
                            state_q <= S_DRAW;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
                S_DRAW: begin
                    if (hit_s) begin
                        self_hit_q <= 1'b1;
                    end
                    if (advance_s) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= 5'd0;
                            state_q <= S_DONE;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
                S_DONE: begin
                    old_q   <= new_q;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    idx_q   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_cell_painter.sv
// Randomized self-checking bench: a cycle timeline is predicted from the erase-then-draw rules.
module tb_snake_cell_painter;

    localparam int LEN   = 31;
    localparam int W     = 16;
    localparam int CELLS = 9600;
    localparam int MAXC  = 256;

    typedef logic [LEN-1:0][W-1:0] pos_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  start_i;
    pos_t  pos_num_i;
    logic  busy_o, done_o, self_hit_o;

    snake_cell_painter_if wr_if ();

    snake_cell_painter #(.LEN(LEN), .W(W), .CELLS(CELLS), .SNAKE_ID(1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .pos_num_i(pos_num_i),
        .busy_o(busy_o), .done_o(done_o), .self_hit_o(self_hit_o), .wr(wr_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] cur_pos   [LEN];
    logic [15:0] model_old [LEN];
    bit          rdy       [MAXC];
    bit          obs_valid [MAXC], obs_busy [MAXC], obs_done [MAXC], obs_hit [MAXC];
    logic [13:0] obs_addr  [MAXC];
    logic [1:0]  obs_data  [MAXC];
    bit          exp_valid [MAXC], exp_busy [MAXC], exp_done [MAXC];
    logic [13:0] exp_addr  [MAXC];
    logic [1:0]  exp_data  [MAXC];
    bit          exp_hit;
    int          exp_done_cyc;
    logic        rst_valid_s, rst_busy_s;

    function automatic bit entry_ok(logic [15:0] e);
        return (e != 16'hffff) && (int'(e) < CELLS);
    endfunction

    function automatic pos_t pack_pos();
        pos_t r;
        for (int j = 0; j < LEN; j++) r[j] = cur_pos[j];
        return r;
    endfunction

    // Timeline: old entries are erased then new ones drawn, one slot per entry plus stalls.
    task automatic build_model(input int rst_cyc);
        int t;
        bit moved;
        logic [15:0] e;
        for (int i = 0; i < MAXC; i++) begin
            exp_valid[i] = 1'b0; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
            exp_addr[i] = 14'd0; exp_data[i] = 2'b00;
        end
        t = 1;
        for (int ph = 0; ph < 2; ph++) begin
            for (int j = 0; j < LEN; j++) begin
                e = (ph == 1) ? cur_pos[j] : model_old[j];
                if (entry_ok(e)) begin
                    moved = 1'b0;
                    while (!moved && t < MAXC) begin
                        exp_valid[t] = 1'b1; exp_busy[t] = 1'b1;
                        exp_addr[t]  = e[13:0];
                        exp_data[t]  = (ph == 1) ? 2'b10 : 2'b00;
                        moved = rdy[t];
                        t++;
                    end
                end else begin
                    if (t < MAXC) exp_busy[t] = 1'b1;
                    t++;
                end
            end
        end
        exp_done_cyc = t;
        if (t < MAXC) begin
            exp_done[t] = 1'b1; exp_busy[t] = 1'b1;
        end
        exp_hit = 1'b0;
        for (int j = 1; j < LEN; j++)
            if (entry_ok(cur_pos[j]) && cur_pos[j] == cur_pos[0]) exp_hit = 1'b1;
        if (rst_cyc > 0) begin
            for (int i = rst_cyc + 1; i < MAXC; i++) begin
                exp_valid[i] = 1'b0; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
            end
            exp_hit = 1'b0;
        end
    endtask

    task automatic run_paint(input bit rnd, input int stall_from, input int stall_len,
                             input int start_again, input int rst_cyc);
        for (int t = 0; t < MAXC; t++)
            rdy[t] = (rnd ? ($urandom_range(0, 3) != 0) : 1'b1) &&
                     !(t >= stall_from && t < stall_from + stall_len);
        build_model(rst_cyc);
        @(negedge clk);
        start_i   = 1'b1;
        pos_num_i = pack_pos();
        for (int t = 1; t < MAXC; t++) begin
            @(negedge clk);
            start_i = (t == start_again);
            for (int j = 0; j < LEN; j++) pos_num_i[j] = 16'($urandom_range(0, 200));
            wr_if.wr_ready = rdy[t];
            obs_valid[t] = wr_if.wr_valid; obs_addr[t] = wr_if.wr_addr;
            obs_data[t]  = wr_if.wr_data;  obs_busy[t] = busy_o;
            obs_done[t]  = done_o;         obs_hit[t]  = self_hit_o;
            if (rst_cyc > 0 && t == rst_cyc) begin
                rst = 1'b1;
                #1;
                rst_valid_s = wr_if.wr_valid;
                rst_busy_s  = busy_o;
            end
            if (rst_cyc > 0 && t == rst_cyc + 1) rst = 1'b0;
        end
        for (int j = 0; j < LEN; j++) model_old[j] = (rst_cyc > 0) ? 16'hffff : cur_pos[j];
        start_i = 1'b0;
        wr_if.wr_ready = 1'b1;
    endtask

    function automatic int first_diff();
        for (int t = 1; t < MAXC; t++) begin
            if (obs_valid[t] !== exp_valid[t] || obs_busy[t] !== exp_busy[t] ||
                obs_done[t] !== exp_done[t]) return t;
            if (exp_valid[t] && (obs_addr[t] !== exp_addr[t] || obs_data[t] !== exp_data[t]))
                return t;
        end
        return 0;
    endfunction

    function automatic int count_done();
        int n = 0;
        for (int t = 1; t < MAXC; t++) if (obs_done[t]) n++;
        return n;
    endfunction

    task automatic set_pos(input int n, input int base, input int step);
        for (int j = 0; j < LEN; j++) cur_pos[j] = (j < n) ? 16'(base + step * j) : 16'hffff;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; pos_num_i = '0; wr_if.wr_ready = 1'b1;
        for (int j = 0; j < LEN; j++) model_old[j] = 16'hffff;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({busy_o, done_o, wr_if.wr_valid, self_hit_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000", {busy_o, done_o, wr_if.wr_valid, self_hit_o});
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({busy_o, done_o, wr_if.wr_valid, self_hit_o, wr_if.wr_addr, wr_if.wr_data} !== 20'd0) begin
                errors++;
                $display("FAIL reset_idle: got busy=%b done=%b valid=%b hit=%b addr=%0d data=%0d expected all 0",
                         busy_o, done_o, wr_if.wr_valid, self_hit_o, wr_if.wr_addr, wr_if.wr_data);
            end
        end
    endtask

    task automatic test_first_paint();
        int d, n;
        set_pos(5, 30, -1);
        run_paint(1'b0, 0, 0, 0, 0);
        d = first_diff();
        checks++;
        if (d !== 0) begin errors++; $display("FAIL first_paint_timeline: first bad cycle %0d expected 0", d); end
        n = 0;
        for (int t = 1; t <= 31; t++) if (obs_valid[t]) n++;
        checks++;
        if (n !== 0) begin errors++; $display("FAIL first_paint_no_erase: got %0d writes expected 0", n); end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (!obs_valid[32+j] || obs_addr[32+j] !== 14'(30 - j) || obs_data[32+j] !== 2'b10) begin
                errors++;
                $display("FAIL first_paint_draw%0d: got v=%b a=%0d d=%0d expected v=1 a=%0d d=2",
                         j, obs_valid[32+j], obs_addr[32+j], obs_data[32+j], 30 - j);
            end
        end
        checks++;
        if (obs_done[63] !== 1'b1 || count_done() !== 1) begin
            errors++; $display("FAIL first_paint_done: got done63=%b count=%0d expected 1/1", obs_done[63], count_done());
        end
        checks++;
        if (obs_hit[63] !== 1'b0) begin errors++; $display("FAIL first_paint_hit: got %b expected 0", obs_hit[63]); end
    endtask

    task automatic test_second_paint();
        int d;
        set_pos(5, 31, -1);
        run_paint(1'b0, 0, 0, 0, 0);
        d = first_diff();
        checks++;
        if (d !== 0) begin errors++; $display("FAIL second_paint_timeline: first bad cycle %0d expected 0", d); end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (!obs_valid[1+j] || obs_addr[1+j] !== 14'(30 - j) || obs_data[1+j] !== 2'b00 ||
                !obs_valid[32+j] || obs_addr[32+j] !== 14'(31 - j) || obs_data[32+j] !== 2'b10) begin
                errors++;
                $display("FAIL second_paint_entry%0d: erase a=%0d d=%0d draw a=%0d d=%0d expected %0d/0 %0d/2",
                         j, obs_addr[1+j], obs_data[1+j], obs_addr[32+j], obs_data[32+j], 30 - j, 31 - j);
            end
        end
    endtask

    task automatic test_backpressure();
        int d, n;
        set_pos(5, 50, 1);
        run_paint(1'b0, 32, 3, 0, 0);
        d = first_diff();
        checks++;
        if (d !== 0) begin errors++; $display("FAIL backpressure_timeline: first bad cycle %0d expected 0", d); end
        for (int t = 32; t <= 35; t++) begin
            checks++;
            if (!obs_valid[t] || obs_addr[t] !== 14'd50 || obs_data[t] !== 2'b10) begin
                errors++;
                $display("FAIL backpressure_stable: cycle %0d got v=%b a=%0d d=%0d expected 1/50/2",
                         t, obs_valid[t], obs_addr[t], obs_data[t]);
            end
        end
        n = 0;
        for (int t = 1; t < MAXC; t++) if (obs_valid[t] && rdy[t]) n++;
        checks++;
        if (n !== 10) begin errors++; $display("FAIL backpressure_transfers: got %0d expected 10", n); end
        checks++;
        if (obs_done[66] !== 1'b1) begin errors++; $display("FAIL backpressure_done66: got %b expected 1", obs_done[66]); end
    endtask

    task automatic test_self_collision();
        int d;
        set_pos(0, 0, 0);
        cur_pos[0] = 16'd130; cur_pos[1] = 16'd131; cur_pos[2] = 16'd11;
        cur_pos[3] = 16'd10;  cur_pos[4] = 16'd130;
        run_paint(1'b0, 0, 0, 0, 0);
        d = first_diff();
        checks++;
        if (d !== 0) begin errors++; $display("FAIL collision_timeline: first bad cycle %0d expected 0", d); end
        checks++;
        if (obs_hit[exp_done_cyc] !== 1'b1 || obs_hit[MAXC-1] !== 1'b1) begin
            errors++; $display("FAIL collision_hit: got done=%b idle=%b expected 1/1", obs_hit[exp_done_cyc], obs_hit[MAXC-1]);
        end
    endtask

    task automatic test_start_ignored();
        int d;
        set_pos(6, 200, 7);
        run_paint(1'b0, 0, 0, 10, 0);
        d = first_diff();
        checks++;
        if (d !== 0) begin errors++; $display("FAIL start_ignored_timeline: first bad cycle %0d expected 0", d); end
        checks++;
        if (count_done() !== 1) begin errors++; $display("FAIL start_ignored_done: got %0d expected 1", count_done()); end
        checks++;
        if (obs_hit[1] !== 1'b0 || obs_hit[MAXC-1] !== 1'b0) begin
            errors++; $display("FAIL start_clears_hit: got %b/%b expected 0/0", obs_hit[1], obs_hit[MAXC-1]);
        end
    endtask

    task automatic test_reset_midrun();
        int d, n;
        set_pos(8, 1000, 3);
        run_paint(1'b0, 0, 0, 0, 40);
        checks++;
        if (rst_valid_s !== 1'b0 || rst_busy_s !== 1'b0) begin
            errors++; $display("FAIL reset_midrun_async: got valid=%b busy=%b expected 0/0", rst_valid_s, rst_busy_s);
        end
        n = 0;
        for (int t = 41; t < MAXC; t++) if (obs_valid[t] || obs_busy[t]) n++;
        checks++;
        if (n !== 0) begin errors++; $display("FAIL reset_midrun_quiet: got %0d active cycles expected 0", n); end
        d = first_diff();
        checks++;
        if (d !== 0) begin errors++; $display("FAIL reset_midrun_timeline: first bad cycle %0d expected 0", d); end
        set_pos(4, 2000, 1);
        run_paint(1'b0, 0, 0, 0, 0);
        n = 0;
        for (int t = 1; t <= 31; t++) if (obs_valid[t]) n++;
        checks++;
        if (n !== 0) begin errors++; $display("FAIL after_reset_erase: got %0d writes expected 0", n); end
        d = first_diff();
        checks++;
        if (d !== 0) begin errors++; $display("FAIL after_reset_timeline: first bad cycle %0d expected 0", d); end
    endtask

    task automatic test_random();
        int d, r;
        for (int it = 0; it < 8; it++) begin
            for (int j = 0; j < LEN; j++) begin
                r = $urandom_range(0, 9);
                if (r < 2)       cur_pos[j] = 16'hffff;
                else if (r == 2) cur_pos[j] = 16'($urandom_range(CELLS, 65534));
                else if (r < 6)  cur_pos[j] = 16'($urandom_range(0, 40));
                else             cur_pos[j] = 16'($urandom_range(0, CELLS - 1));
            end
            if ($urandom_range(0, 1) == 1) cur_pos[$urandom_range(1, LEN - 1)] = cur_pos[0];
            run_paint(1'b1, 0, 0, (it % 2 == 0) ? 20 : 0, 0);
            d = first_diff();
            checks++;
            if (d !== 0) begin errors++; $display("FAIL random%0d_timeline: first bad cycle %0d expected 0", it, d); end
            checks++;
            if (count_done() !== 1) begin errors++; $display("FAIL random%0d_done: got %0d expected 1", it, count_done()); end
            checks++;
            if (obs_hit[MAXC-1] !== exp_hit) begin
                errors++; $display("FAIL random%0d_hit: got %b expected %b", it, obs_hit[MAXC-1], exp_hit);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_paint();
        test_second_paint();
        test_backpressure();
        test_self_collision();
        test_start_ignored();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
